// File: rtl/ir_frame_decoder.sv
// Pulse-width IR frame decoder: synchronizes the IR line, classifies each high pulse
// by its width and assembles START + DATA_W bits (+ optional even parity) into a word.
module ir_frame_decoder #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 5,
    parameter int LOW_TH    = 4,
    parameter int HIGH_TH   = 9,
    parameter int START_TH  = 14,
    parameter int TIMEOUT   = 30,
    parameter int PARITY_EN = 0
) (
    input  logic              IR_READER_CLK,
    input  logic              reset,
    input  logic              ir_signal,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] ir_reader_out,
    output logic              avail,
    output logic              frame_err,
    output logic              overrun
);

    localparam int              BC_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LOW_C     = CNT_W'(LOW_TH);
    localparam logic [CNT_W-1:0] HIGH_C    = CNT_W'(HIGH_TH);
    localparam logic [CNT_W-1:0] START_C   = CNT_W'(START_TH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
    typedef enum logic [2:0] {SYM_NONE, SYM_GLITCH, SYM_BIT0, SYM_BIT1, SYM_START} sym_t;

    logic              s1, s2, s2_d;
    logic              fall;
    logic [CNT_W-1:0]  pulse_cnt, gap_cnt;
    state_t            state, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
    sym_t              sym;
    logic              is_bit, bit_val, timed_out;
    logic              done, err;
    logic [DATA_W-1:0] word;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge IR_READER_CLK) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= ir_signal;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign fall = !s2 && s2_d;

    // During the fall cycle pulse_cnt holds the full high width of the pulse just ended.
    always_ff @(posedge IR_READER_CLK) begin
        if (reset) begin
            pulse_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            if (fall)
                pulse_cnt <= '0;
            else if (s2 && pulse_cnt != CNT_MAX)
                pulse_cnt <= pulse_cnt + 1'b1;

            if (s2)
                gap_cnt <= '0;
            else if (gap_cnt != CNT_MAX)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        sym = SYM_NONE;
        if (fall) begin
            if (pulse_cnt >= START_C)     sym = SYM_START;
            else if (pulse_cnt >= HIGH_C) sym = SYM_BIT1;
            else if (pulse_cnt >= LOW_C)  sym = SYM_BIT0;
            else                          sym = SYM_GLITCH;
        end
    end

    assign is_bit    = (sym == SYM_BIT0) || (sym == SYM_BIT1);
    assign bit_val   = (sym == SYM_BIT1);
    assign timed_out = (gap_cnt == TIMEOUT_C);

    always_comb begin
        state_n   = state;
        shift_n   = shift_q;
        bit_cnt_n = bit_cnt;
        done      = 1'b0;
        err       = 1'b0;
        word      = shift_q;
        case (state)
            IDLE: begin
                if (sym == SYM_START) begin
                    state_n   = DATA;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            DATA, PAR: begin
                if (timed_out) begin
                    err       = 1'b1;
                    state_n   = IDLE;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                end else if (sym == SYM_START) begin
                    state_n   = DATA;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                end else if (is_bit && state == DATA) begin
                    shift_n   = {shift_q[DATA_W-2:0], bit_val};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_n = PAR;
                        end else begin
                            done      = 1'b1;
                            word      = shift_n;
                            state_n   = IDLE;
                            bit_cnt_n = '0;
                        end
                    end
                end else if (is_bit) begin
                    // Even parity: payload bits plus the parity bit must XOR to zero.
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                    if (((^shift_q) ^ bit_val) == 1'b0)
                        done = 1'b1;
                    else
                        err = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge IR_READER_CLK) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    // A completion coinciding with rd_ack hands over the new word without an overrun.
    always_ff @(posedge IR_READER_CLK) begin
        if (reset) begin
            ir_reader_out <= '0;
            avail         <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= err;
            overrun   <= done && avail && !rd_ack;
            if (done) begin
                ir_reader_out <= word;
                avail         <= 1'b1;
            end else if (rd_ack) begin
                avail <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ir_frame_decoder.md
IR_FRAME_DECODER -- requirements
Module: ir_frame_decoder

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame.
REQ-002 Parameter CNT_W, default 5: width of the pulse and gap counters; SHALL satisfy 2^CNT_W-1 > START_TH and 2^CNT_W-1 > TIMEOUT.
REQ-003 Parameter LOW_TH, default 4: minimum high width, in cycles, of a valid symbol.
REQ-004 Parameter HIGH_TH, default 9: minimum high width, in cycles, of a '1' bit.
REQ-005 Parameter START_TH, default 14: minimum high width, in cycles, of a start symbol.
REQ-006 Parameter TIMEOUT, default 30: maximum low gap, in cycles, inside a frame.
REQ-007 Parameter PARITY_EN, default 0: when 1, an even-parity bit follows the payload.
REQ-008 IR_READER_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 ir_signal  in  1  asynchronous IR line; high means a pulse is present.
REQ-011 rd_ack  in  1  consumer acknowledge of the held word.
REQ-012 ir_reader_out  out  DATA_W  last accepted payload.
REQ-013 avail  out  1  ir_reader_out holds an unread word.
REQ-014 frame_err  out  1  one-cycle pulse on a timeout or parity failure.
REQ-015 overrun  out  1  one-cycle pulse when an unread word is overwritten.

Function
REQ-016 ir_signal SHALL pass through a 2-flop synchronizer (s2 = synchronized level); a fall SHALL be detected when s2=0 and s2 was 1 on the previous cycle.
REQ-017 The pulse counter SHALL increment each cycle s2=1, saturate at 2^CNT_W-1, and clear to 0 on the cycle after a fall.
REQ-018 The gap counter SHALL increment each cycle s2=0, saturate at 2^CNT_W-1, and clear when s2=1.
REQ-019 On a fall, width w SHALL be classified as follows: w>=START_TH is START; HIGH_TH<=w<START_TH is BIT1; LOW_TH<=w<HIGH_TH is BIT0; w<LOW_TH is GLITCH.
REQ-020 GLITCH SHALL change no state, counters excepted.
REQ-021 FSM states SHALL be IDLE, DATA and PAR.
REQ-022 IDLE: START SHALL go to DATA with bit count 0; BIT0 and BIT1 SHALL be ignored.
REQ-023 DATA: each BIT0/BIT1 SHALL shift into the LSB of the shift register, MSB first, and increment the bit count.
REQ-024 DATA: on the DATA_W-th bit, the FSM SHALL go to PAR if PARITY_EN=1, otherwise complete the frame and go to IDLE.
REQ-025 PAR: the next BIT0/BIT1 SHALL be checked; XOR of the payload and the parity bit = 0 SHALL complete the frame, otherwise pulse frame_err; either outcome SHALL go to IDLE.
REQ-026 START received in DATA or PAR SHALL discard partial bits and restart DATA with bit count 0, with no error.
REQ-027 In DATA or PAR, a gap counter value reaching TIMEOUT SHALL pulse frame_err once and go to IDLE, discarding partial bits.
REQ-028 Frame completion SHALL load ir_reader_out and set avail, registered on the cycle after the fall is detected, i.e. the 3rd rising edge after ir_signal falls.
REQ-029 rd_ack with avail=1 SHALL clear avail on the next edge; rd_ack with avail=0 SHALL be ignored.
REQ-030 Completion while avail=1 and rd_ack=0 SHALL overwrite ir_reader_out, keep avail=1 and pulse overrun.
REQ-031 Completion in the same cycle as rd_ack SHALL load the new word, keep avail=1 and not pulse overrun.
REQ-032 frame_err and overrun SHALL be high for exactly one cycle per event.

Reset
REQ-033 Reset SHALL clear: FSM to IDLE; synchronizer, both counters, shift register and bit count to 0; ir_reader_out=0; avail=0; frame_err=0; overrun=0.
REQ-034 Reset SHALL override every other input in the same cycle, including mid-frame; no frame_err is produced.

Verification (defaults, PARITY_EN=0 unless noted)
REQ-035 Start 16 cycles high, then bits 1,0,1,0,0,1,0,1 (1 = 11 high, 0 = 6 high, 3-cycle low gaps) -> ir_reader_out=0xA5, avail=1 on the 3rd edge after the last fall.
REQ-036 Same frame with 2-cycle glitches inserted between bits -> ir_reader_out=0xA5, no frame_err.
REQ-037 Start then 3 bits, then low for 40 cycles -> exactly one frame_err pulse, avail stays 0, and a following 0x3C frame decodes correctly.
REQ-038 Send 0x11 with no rd_ack, then 0x22 -> overrun pulses once and ir_reader_out=0x22; then rd_ack -> avail=0 next edge.
REQ-039 PARITY_EN=1: 0x0F with parity 0 -> avail=1; 0x0F with parity 1 -> frame_err pulse, ir_reader_out unchanged.
REQ-040 Reset asserted after 4 bits of a frame -> all outputs 0; next full frame 0x5A -> ir_reader_out=0x5A.
